// File: rtl/conv_deser_pkg.sv
// Shared types and constants for the DDR sync-aligned deserializer.
// Pure declarations; no logic, no latency, no flow control.
package conv_deser_pkg;

    typedef enum logic {
        ST_ALIGN  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;

    function automatic int cnt_width(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/ddr_in_capture.sv
// DDR input capture: H sampled on the falling edge, presented with live L as a pair.
// Zero added latency for L, half a cycle for H; no backpressure (free-running).
module ddr_in_capture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [1:0] pair
);

    logic neg_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= serial_in;
        end
    end

    // H arrived earlier on the wire, so it sits in the upper bit
    assign pair = {neg_q, serial_in};

endmodule

// File: rtl/conv_tree_deserializer_16.sv
// DDR serial to WIDTH-bit words, aligned on SYNC_WORD; word visible 2 cycles after its last bit.
// 2-entry output buffer; a push into a full buffer with no pop drops the word and sets sticky OVERFLOW.
module conv_tree_deserializer_16
    import conv_deser_pkg::*;
#(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(SYNC_WORD_DEFAULT),
    parameter bit              DROP_SYNC  = 1'b1,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SERIAL_IN,
    input  logic             RESYNC,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             LOCKED,
    output logic             OVERFLOW
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_WRAP = CW'(WIDTH / 2 - 1);

    logic [1:0]       pair;
    logic [WIDTH:0]   sr;
    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             match0, match1;
    logic [WIDTH-1:0] word_cur;
    logic             push_d, push_q;
    logic [WIDTH-1:0] word_q;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic             pop, full, wr_en;

    ddr_in_capture u_capture (
        .clk       (CLK),
        .rst_n     (RST_N),
        .serial_in (SERIAL_IN),
        .pair      (pair)
    );

    assign match0   = (sr[WIDTH-1:0] == SYNC_WORD);
    assign match1   = (sr[WIDTH:1] == SYNC_WORD);
    assign word_cur = phase_q ? sr[WIDTH:1] : sr[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        push_d  = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                if (match0 || match1) begin
                    state_d = ST_LOCKED;
                    phase_d = !match0;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                cnt_d = (cnt_q == CNT_WRAP) ? '0 : cnt_q + CW'(1);
                // sr already holds the whole word when the counter sits at its wrap value
                if (cnt_q == CNT_WRAP) begin
                    push_d = !(DROP_SYNC && (word_cur == SYNC_WORD));
                end
            end
            default: state_d = ST_ALIGN;
        endcase
        if (RESYNC) begin
            state_d = ST_ALIGN;
            cnt_d   = '0;
            push_d  = 1'b0;
        end
    end

    assign pop   = OUT_VALID && OUT_READY;
    assign full  = (count == 2'(FIFO_DEPTH));
    assign wr_en = push_q && (!full || pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr       <= '0;
            state_q  <= ST_ALIGN;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            push_q   <= 1'b0;
            word_q   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            OVERFLOW <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sr      <= {sr[WIDTH-2:0], pair};
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            word_q  <= word_cur;
            if (wr_en) begin
                mem[wr_ptr] <= word_q;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(pop);
            if (push_q && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    assign PAR_OUT   = mem[rd_ptr];
    assign OUT_VALID = (count != 2'd0);
    assign LOCKED    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_conv_tree_deserializer_16.sv
// Directed bench for conv_tree_deserializer_16: bit-queue stimulus, word scoreboards per instance.
// Instance a drops in-stream sync words, instance b delivers them.
module tb_conv_tree_deserializer_16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        SERIAL_IN = 1'b0;
    logic        RESYNC = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [15:0] par_a, par_b;
    logic        vld_a, vld_b, lock_a, lock_b, ovf_a, ovf_b;

    int          total = 0;
    int          bad = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    bit          bits[$];
    logic        ready_req = 1'b0;
    logic        resync_req = 1'b0;
    logic [15:0] exp_a, exp_b;

    always #5 CLK = ~CLK;

    conv_tree_deserializer_16 #(.DROP_SYNC(1'b1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .SERIAL_IN(SERIAL_IN), .RESYNC(RESYNC),
        .PAR_OUT(par_a), .OUT_VALID(vld_a), .OUT_READY(OUT_READY),
        .LOCKED(lock_a), .OVERFLOW(ovf_a)
    );

    conv_tree_deserializer_16 #(.DROP_SYNC(1'b0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .SERIAL_IN(SERIAL_IN), .RESYNC(RESYNC),
        .PAR_OUT(par_b), .OUT_VALID(vld_b), .OUT_READY(OUT_READY),
        .LOCKED(lock_b), .OVERFLOW(ovf_b)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic check_empty(input string tag);
        total++;
        assert (q_a.size() == 0 && q_b.size() == 0) else begin
            bad++;
            $error("FAIL %s: observed pending a=%0d b=%0d expected 0", tag, q_a.size(), q_b.size());
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) bits.push_back(1'b0);
    endtask

    // One CLK cycle: H driven after posedge (taken at negedge), L driven after negedge (taken at next posedge)
    task automatic step_pair();
        bit h, l;
        h = (bits.size() > 0) ? bits.pop_front() : 1'b0;
        l = (bits.size() > 0) ? bits.pop_front() : 1'b0;
        @(posedge CLK);
        #1;
        SERIAL_IN  = h;
        OUT_READY  = ready_req;
        RESYNC     = resync_req;
        resync_req = 1'b0;
        @(negedge CLK);
        #1;
        SERIAL_IN = l;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_pair();
    endtask

    task automatic run_all();
        while (bits.size() > 0) step_pair();
    endtask

    task automatic do_reset();
        #1;
        RST_N = 1'b0;
        q_a.delete();
        q_b.delete();
        bits.delete();
        ready_req  = 1'b0;
        resync_req = 1'b0;
        RESYNC     = 1'b0;
        OUT_READY  = 1'b0;
        SERIAL_IN  = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Scoreboard pop: a transfer happens at the next posedge when valid and ready are both high
    always @(negedge CLK) begin
        if (RST_N && vld_a && OUT_READY) begin
            total++;
            assert (q_a.size() > 0) else begin
                bad++;
                $error("FAIL word_a: observed=%04h expected=none", par_a);
            end
            if (q_a.size() > 0) begin
                exp_a = q_a.pop_front();
                total++;
                assert (par_a === exp_a) else begin
                    bad++;
                    $error("FAIL word_a: observed=%04h expected=%04h", par_a, exp_a);
                end
            end
        end
        if (RST_N && vld_b && OUT_READY) begin
            total++;
            assert (q_b.size() > 0) else begin
                bad++;
                $error("FAIL word_b: observed=%04h expected=none", par_b);
            end
            if (q_b.size() > 0) begin
                exp_b = q_b.pop_front();
                total++;
                assert (par_b === exp_b) else begin
                    bad++;
                    $error("FAIL word_b: observed=%04h expected=%04h", par_b, exp_b);
                end
            end
        end
    end

    initial begin
        // reset state
        #2;
        check_word("rst_par", par_a, 16'h0000);
        check_bit("rst_vld", vld_a, 1'b0);
        check_bit("rst_lock", lock_a, 1'b0);
        check_bit("rst_ovf", ovf_a, 1'b0);
        do_reset();

        // phase-0 lock, latency of LOCKED and of each word
        ready_req = 1'b1;
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h1234); q_a.push_back(16'h1234); q_b.push_back(16'h1234);
        push_word(16'h8001); q_a.push_back(16'h8001); q_b.push_back(16'h8001);
        run(10);
        run(1); check_bit("p0_lock_t0", lock_a, 1'b0);
        run(1); check_bit("p0_lock_t1", lock_a, 1'b1);
        run(6);
        run(1); check_bit("p0_w1_vld_t0", vld_a, 1'b0);
        run(1); check_bit("p0_w1_vld_t1", vld_a, 1'b0);
        run(1); check_bit("p0_w1_vld_t2", vld_a, 1'b1); check_word("p0_w1_par", par_a, 16'h1234);
        run(5);
        run(1); check_bit("p0_w2_vld_t0", vld_a, 1'b0);
        run(1); check_bit("p0_w2_vld_t1", vld_a, 1'b0);
        run(1); check_bit("p0_w2_vld_t2", vld_a, 1'b1); check_word("p0_w2_par", par_a, 16'h8001);
        resync_req = 1'b1;
        run(4);
        check_bit("p0_unlock", lock_a, 1'b0);
        check_empty("p0_drained");

        // phase-1 lock after one odd garbage bit
        do_reset();
        ready_req = 1'b1;
        pad(5);
        push_word(16'hA5C3);
        push_word(16'hBEEF); q_a.push_back(16'hBEEF); q_b.push_back(16'hBEEF);
        pad(1);
        run_all();
        run(3);
        check_bit("p1_vld", vld_a, 1'b1);
        check_word("p1_par", par_a, 16'hBEEF);
        check_bit("p1_lock_b", lock_b, 1'b1);
        run(2);
        check_empty("p1_drained");

        // backpressure and overflow
        do_reset();
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h0001); q_a.push_back(16'h0001); q_b.push_back(16'h0001);
        push_word(16'h0002); q_a.push_back(16'h0002); q_b.push_back(16'h0002);
        push_word(16'h0003);
        run_all();
        run(1);
        run(1); check_bit("bp_ovf_t1", ovf_a, 1'b0);
        run(1); check_bit("bp_ovf_t2", ovf_a, 1'b1);
        check_bit("bp_vld", vld_a, 1'b1);
        check_word("bp_head", par_a, 16'h0001);
        resync_req = 1'b1;
        ready_req  = 1'b1;
        run(5);
        check_bit("bp_drained_vld", vld_a, 1'b0);
        check_bit("bp_ovf_sticky", ovf_a, 1'b1);
        check_empty("bp_drained");

        // asynchronous reset mid-word with a held word and OVERFLOW set
        ready_req = 1'b0;
        pad(2);
        push_word(16'hA5C3);
        push_word(16'h0004);
        push_word(16'h0005);
        run(21);
        check_bit("ar_lock_pre", lock_a, 1'b1);
        check_word("ar_par_pre", par_a, 16'h0004);
        #2;
        RST_N = 1'b0;
        #1;
        check_word("ar_par", par_a, 16'h0000);
        check_bit("ar_vld", vld_a, 1'b0);
        check_bit("ar_lock", lock_a, 1'b0);
        check_bit("ar_ovf", ovf_a, 1'b0);
        do_reset();
        ready_req = 1'b1;
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h1357); q_a.push_back(16'h1357); q_b.push_back(16'h1357);
        run_all();
        run(4);
        resync_req = 1'b1;
        run(2);
        check_empty("ar_relock");

        // full buffer with simultaneous pop on the push cycle
        do_reset();
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h0001); q_a.push_back(16'h0001); q_b.push_back(16'h0001);
        push_word(16'h0002); q_a.push_back(16'h0002); q_b.push_back(16'h0002);
        push_word(16'h0003); q_a.push_back(16'h0003); q_b.push_back(16'h0003);
        run_all();
        run(1);
        ready_req = 1'b1;
        run(1); check_word("fp_head_full", par_a, 16'h0001);
        run(1); check_bit("fp_ovf", ovf_a, 1'b0); check_word("fp_head_next", par_a, 16'h0002);
        resync_req = 1'b1;
        run(5);
        check_bit("fp_ovf_end", ovf_a, 1'b0);
        check_empty("fp_drained");

        // in-stream sync word: dropped by a, delivered by b
        do_reset();
        ready_req = 1'b1;
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h1111); q_a.push_back(16'h1111); q_b.push_back(16'h1111);
        push_word(16'hA5C3); q_b.push_back(16'hA5C3);
        push_word(16'h2222); q_a.push_back(16'h2222); q_b.push_back(16'h2222);
        run_all();
        run(4);
        check_bit("ds_lock_a", lock_a, 1'b1);
        resync_req = 1'b1;
        run(3);
        check_empty("ds_drained");

        // RESYNC mid-word, relock, then RESYNC on a word's completion cycle
        do_reset();
        ready_req = 1'b1;
        pad(4);
        push_word(16'hA5C3);
        push_word(16'h4444);
        run(11);
        run(1); check_bit("rs_lock", lock_a, 1'b1);
        run(2);
        resync_req = 1'b1;
        run(1);
        run(1); check_bit("rs_unlock", lock_a, 1'b0);
        run_all();
        run(6);
        check_bit("rs_no_partial", vld_a, 1'b0);
        pad(2);
        push_word(16'hA5C3);
        push_word(16'h5555); q_a.push_back(16'h5555); q_b.push_back(16'h5555);
        push_word(16'h6666);
        run_all();
        resync_req = 1'b1;
        run(1);
        run(4);
        check_bit("rs_wrap_drop_vld", vld_a, 1'b0);
        check_bit("rs_wrap_unlock", lock_a, 1'b0);
        check_empty("rs_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
